// File: rtl/cvsd_encoder.sv
// +----------------------------------------------------------------------------+
// | Module  : cvsd_encoder                                                     |
// | Brief   : CVSD encoder; one delta bit per 16-bit PCM sample with adaptive  |
// |           step and saturating reconstruction integrator.                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module cvsd_encoder #(
  parameter int D_MIN      = 10,
  parameter int D_MAX      = 1280,
  parameter int LEAK_SHIFT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pcm_valid_i,
  output logic        pcm_ready_o,
  input  logic [15:0] pcm_i,
  output logic        bit_valid_o,
  input  logic        bit_ready_i,
  output logic        bit_o,
  output logic [15:0] step_o,
  output logic [15:0] est_o
);

  localparam logic [15:0]        c_D_MIN   = 16'(D_MIN);
  localparam logic [15:0]        c_D_MAX   = 16'(D_MAX);
  localparam logic signed [17:0] c_SAT_HI  = 18'sd32767;
  localparam logic signed [17:0] c_SAT_LO  = -18'sd32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_pcm_ready;
  logic               r_bit_valid;
  logic               r_bit;
  logic [15:0]        r_step;
  logic signed [15:0] r_est;
  logic signed [15:0] r_pcm;
  logic [1:0]         r_hist;   // {h1, h0}

  logic               w_b;
  logic               w_c;
  logic [16:0]        w_grow;
  logic [25:0]        w_dec26;
  logic [15:0]        w_dec;
  logic [15:0]        w_step_n;
  logic signed [17:0] w_est_ext;
  logic signed [17:0] w_e1;
  logic signed [17:0] w_est_n;
  logic signed [15:0] w_est_sat;

  assign w_b = (r_pcm >= r_est);
  assign w_c = (w_b == r_hist[1]) && (r_hist[1] == r_hist[0]);

  // Decay is floor(step*1023/1024), done exactly with a shift-subtract.
  assign w_grow  = {1'b0, r_step} + {1'b0, c_D_MIN};
  assign w_dec26 = {r_step, 10'b0} - {10'b0, r_step};
  assign w_dec   = 16'(w_dec26 >> 10);

  always_comb begin
    w_step_n = c_D_MIN;
    if (w_c) begin
      w_step_n = (w_grow > {1'b0, c_D_MAX}) ? c_D_MAX : w_grow[15:0];
    end else begin
      w_step_n = (w_dec < c_D_MIN) ? c_D_MIN : w_dec;
    end
  end

  assign w_est_ext = {{2{r_est[15]}}, r_est};

  generate
    if (LEAK_SHIFT == 0) begin : g_no_leak
      assign w_e1 = w_est_ext;
    end else begin : g_leak
      assign w_e1 = w_est_ext - (w_est_ext >>> LEAK_SHIFT);
    end
  endgenerate

  assign w_est_n = w_b ? (w_e1 + $signed({2'b00, w_step_n}))
                       : (w_e1 - $signed({2'b00, w_step_n}));

  always_comb begin
    w_est_sat = w_est_n[15:0];
    if (w_est_n > c_SAT_HI) begin
      w_est_sat = 16'sh7FFF;
    end else if (w_est_n < c_SAT_LO) begin
      w_est_sat = -16'sh8000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_pcm_ready <= 1'b1;
      r_bit_valid <= 1'b0;
      r_bit       <= 1'b0;
      r_step      <= 16'd0;
      r_est       <= 16'sd0;
      r_pcm       <= 16'sd0;
      r_hist      <= 2'b01;
    end else begin
      case (r_state)
        IDLE: begin
          if (pcm_valid_i) begin
            r_pcm       <= pcm_i;
            r_pcm_ready <= 1'b0;
            r_state     <= CALC;
          end
        end
        CALC: begin
          r_bit       <= w_b;
          r_step      <= w_step_n;
          r_est       <= w_est_sat;
          r_hist      <= {w_b, r_hist[1]};
          r_bit_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (bit_ready_i) begin
            r_bit_valid <= 1'b0;
            r_pcm_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_bit_valid <= 1'b0;
          r_pcm_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign pcm_ready_o = r_pcm_ready;
  assign bit_valid_o = r_bit_valid;
  assign bit_o       = r_bit;
  assign step_o      = r_step;
  assign est_o       = r_est;

endmodule

`default_nettype wire

// File: doc/cvsd_encoder.md
Name: cvsd_encoder

Overview:
- CVSD encoder: turns 16-bit signed PCM samples into one delta bit per sample.
- Runs an internal reconstruction integrator and step-size adapter. Their update rules are bit-exact with the codec's decoder-side step adapter, so a decoder fed this bitstream tracks the same estimate.
- Sits between the PCM sample source (valid/ready) and the serial bit sink (valid/ready).

Parameters:
- D_MIN, 10: minimum step size; floor of the decay rule.
- D_MAX, 1280: maximum step size; cap of the growth rule.
- LEAK_SHIFT, 0: integrator leak shift. 0 disables the leak; otherwise est -= est>>>LEAK_SHIFT before each step update.

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_ni  in  1  synchronous reset, active-low.
- pcm_valid_i  in  1  PCM sample offered.
- pcm_ready_o  out  1  encoder can accept a sample.
- pcm_i  in  16  signed two's-complement PCM sample.
- bit_valid_o  out  1  encoded bit available.
- bit_ready_i  in  1  sink accepts bit.
- bit_o  out  1  encoded delta bit.
- step_o  out  16  current step size (monitor).
- est_o  out  16  current signed integrator estimate (monitor).

Behaviour:
- Reset (rst_ni=0 at a clock edge), all from the next cycle:
  - state=IDLE, pcm_ready_o=1, bit_valid_o=0, bit_o=0, step_o=0, est_o=0.
  - Bit history {h1,h0}=2'b01, so the first two bits can never coincide.
  - Reset overrides every other input, in every state including mid-SEND; any pending bit is discarded.
- FSM states:
  - IDLE: pcm_ready_o=1. On pcm_valid_i=1, latch pcm_i, go to CALC.
  - CALC: one cycle, pcm_ready_o=0. Compute and register b, step, est and history; go to SEND.
  - SEND: bit_valid_o=1, bit_o=b, held stable. On bit_ready_i=1, go to IDLE.
  - Minimum throughput: 3 cycles per sample. Latency from accept edge to bit_valid_o high is 2 cycles.
- Bit decision: b = (pcm >= est) signed compare; equality gives 1.
- Coincidence: c = (b==h1) && (h1==h0). History update: h0<=h1, h1<=b.
- Step adapt, with step as 16-bit unsigned:
  - c=1: step_n = min(step+D_MIN, D_MAX).
  - c=0: step_n = max(floor(step*1023/1024), D_MIN). Compute it as ({step,10'b0}-step)>>10 in 26-bit arithmetic.
  - From step=0: c=0 gives 10, c=1 gives 10.
- Integrator:
  - e1 = est - (est>>>LEAK_SHIFT), or e1 = est when LEAK_SHIFT=0.
  - est_n = e1 + step_n if b=1, else e1 - step_n.
  - Computed in 18-bit signed, then saturated to [-32768, 32767]. No wrap-around is ever permitted.
- step_o and est_o update only at the CALC edge and are stable otherwise.
- pcm_valid_i is ignored outside IDLE. Samples offered while busy are not consumed because pcm_ready_o=0.
- SEND with bit_ready_i=1 returns to IDLE; a new sample can be accepted on the following cycle. There is no same-cycle accept.
- bit_ready_i outside SEND has no effect.

Test Plan:
1. Reset: hold rst_ni=0 for 3 cycles with pcm_valid_i=1 and bit_ready_i=1 -> pcm_ready_o=1, bit_valid_o=0, step_o=0, est_o=0 throughout.
2. Ramp-up, LEAK_SHIFT=0, bit_ready_i=1, pcm_i=1000 repeatedly:
   - Bits 1,1,1,1,1.
   - step_o 10,10,20,30,40; est_o 10,20,40,70,110.
   - bit_valid_o first rises 2 cycles after accept.
3. Alternation: pcm_i=+5000, then -5000, alternating -> bits 1,0,1,0, no coincidence. step_o stays at 10 (floor). est_o follows 10,0,10,0.
4. Saturation: drive pcm_i=32767 for 300 samples:
   - step_o climbs to 1280 and stays there.
   - est_o reaches 32767 and never wraps negative.
   - Then drive pcm_i=-32768: step decays 1280->1278->1276 until coincidence resumes growth.
5. Backpressure: hold bit_ready_i=0 for 10 cycles in SEND -> bit_valid_o=1 and bit_o stable, pcm_ready_o=0, pcm_valid_i toggling has no effect. Release -> IDLE next cycle.
6. Reset in SEND: after 3 samples, assert rst_ni=0 while bit_valid_o=1 -> next cycle bit_valid_o=0, step_o=0, est_o=0. A following pcm_i=100 yields bit 1, step_o 10, est_o 10.
